// File: rtl/vga_timing.sv
// VGA raster timing generator: a pixel-rate divider feeding horizontal and
// vertical counters, with sync, active-region, start markers and a sticky vblank flag.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 1,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        vblank_ack,
    output logic        pix_stb,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_irq
);

    localparam logic [10:0] H_TOTAL   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] V_TOTAL   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);

    logic        run_r;
    logic [3:0]  div_cnt_r;
    logic [10:0] h_cnt_r;
    logic [10:0] v_cnt_r;
    logic        irq_r;

    logic        pix_stb_s;
    logic        h_wrap_s;
    logic        v_wrap_s;
    logic        irq_set_s;

    // Strobe and wrap decodes shared by the counters and the outputs
    always_comb begin
        pix_stb_s = run_r && (div_cnt_r == DIV_LAST);
        h_wrap_s  = (h_cnt_r == (H_TOTAL - 11'd1));
        v_wrap_s  = (v_cnt_r == (V_TOTAL - 11'd1));
        irq_set_s = pix_stb_s && (h_cnt_r == 11'd0) && (v_cnt_r == V_ACT);
    end

    // Run flag, pixel divider and raster counters; enable low parks everything at zero
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_r     <= 1'b0;
            div_cnt_r <= 4'd0;
            h_cnt_r   <= 11'd0;
            v_cnt_r   <= 11'd0;
        end else begin
            run_r <= enable;
            if (!enable) begin
                div_cnt_r <= 4'd0;
                h_cnt_r   <= 11'd0;
                v_cnt_r   <= 11'd0;
            end else if (run_r) begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_r <= 4'd0;
                end else begin
                    div_cnt_r <= div_cnt_r + 4'd1;
                end
                if (pix_stb_s) begin
                    if (h_wrap_s) begin
                        h_cnt_r <= 11'd0;
                        if (v_wrap_s) begin
                            v_cnt_r <= 11'd0;
                        end else begin
                            v_cnt_r <= v_cnt_r + 11'd1;
                        end
                    end else begin
                        h_cnt_r <= h_cnt_r + 11'd1;
                    end
                end else begin
                    h_cnt_r <= h_cnt_r;
                end
            end else begin
                div_cnt_r <= div_cnt_r;
            end
        end
    end

    // Sticky vblank flag: a set in the same cycle as an ack takes precedence
    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq_r <= 1'b0;
        end else if (irq_set_s) begin
            irq_r <= 1'b1;
        end else if (vblank_ack) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    // Output decode from state only, so no input reaches an output combinationally
    always_comb begin
        pix_stb     = 1'b0;
        pix_x       = 11'd0;
        pix_y       = 11'd0;
        active      = 1'b0;
        hsync       = ~SYNC_POL;
        vsync       = ~SYNC_POL;
        line_start  = 1'b0;
        frame_start = 1'b0;
        vblank_irq  = irq_r;
        if (run_r) begin
            pix_stb     = pix_stb_s;
            pix_x       = h_cnt_r;
            pix_y       = v_cnt_r;
            active      = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
            hsync       = ((h_cnt_r >= H_SYNC_LO) && (h_cnt_r < H_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
            vsync       = ((v_cnt_r >= V_SYNC_LO) && (v_cnt_r < V_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
            line_start  = pix_stb_s && (h_cnt_r == 11'd0);
            frame_start = pix_stb_s && (h_cnt_r == 11'd0) && (v_cnt_r == 11'd0);
        end else begin
            pix_stb     = 1'b0;
            active      = 1'b0;
        end
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 SHALL have parameters V_FP 10, V_SYNC 2, V_BP 33: vertical front porch, sync and back porch, in lines.
REQ-007 SHALL have parameter CLK_DIV, default 1: clk cycles per pixel, legal range 1..16.
REQ-008 SHALL have parameter SYNC_POL, default 0: active level of hsync and vsync.
REQ-009 SHALL have clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-010 SHALL have resetn, input, 1 bit: reset, synchronous, active-low.
REQ-011 SHALL have enable, input, 1 bit: run timing when high; hold idle when low.
REQ-012 SHALL have vblank_ack, input, 1 bit: single-cycle clear of vblank_irq.
REQ-013 SHALL have pix_stb, output, 1 bit: pixel advance strobe.
REQ-014 SHALL have pix_x, output, 11 bits, and pix_y, output, 11 bits: current h_cnt and v_cnt.
REQ-015 SHALL have active, output, 1 bit: current pixel is in the visible region.
REQ-016 SHALL have hsync and vsync, outputs, 1 bit each: sync pulses at SYNC_POL level.
REQ-017 SHALL have line_start and frame_start, outputs, 1 bit each: one-cycle markers.
REQ-018 SHALL have vblank_irq, output, 1 bit: sticky vertical-blank flag.

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, each at most 2047.
REQ-020 SHALL hold registers run, div_cnt, h_cnt, v_cnt and irq; run is enable registered.
REQ-021 SHALL drive every output as a decode of those registers, with no combinational path from any input to any output.
REQ-022 SHALL assert pix_stb = run && div_cnt==CLK_DIV-1; CLK_DIV=1 gives pix_stb every run cycle.
REQ-023 SHALL, while run=1, step div_cnt 0..CLK_DIV-1 and wrap it to 0.
REQ-024 SHALL, on a pix_stb cycle, increment h_cnt, or wrap it to 0 at H_TOTAL-1.
REQ-025 SHALL, on that h_cnt wrap, increment v_cnt, or wrap it to 0 at V_TOTAL-1.
REQ-026 SHALL load div_cnt, h_cnt and v_cnt with 0 on the next edge in any cycle where enable=0.
REQ-027 SHALL, while run=0, force active=0, hsync and vsync to ~SYNC_POL, and pix_stb, line_start and frame_start to 0.
REQ-028 SHALL assert active = run && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
REQ-029 SHALL drive hsync = SYNC_POL when run and H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise ~SYNC_POL.
REQ-030 SHALL drive vsync = SYNC_POL when run and V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines; otherwise ~SYNC_POL.
REQ-031 SHALL assert line_start = pix_stb && h_cnt==0 and frame_start = pix_stb && h_cnt==0 && v_cnt==0.
REQ-032 SHALL drive pix_x = h_cnt and pix_y = v_cnt, including in blanking, and 0 while idle.
REQ-033 SHALL set irq on the edge ending a pix_stb cycle with h_cnt==0 && v_cnt==V_ACTIVE; vblank_irq = irq.
REQ-034 SHALL clear irq on the edge after a vblank_ack=1 cycle; a simultaneous set wins.
REQ-035 SHALL keep irq unchanged when enable drops.

Reset
REQ-036 SHALL, with resetn=0 at an edge, clear run, div_cnt, h_cnt, v_cnt and irq.
REQ-037 SHALL, in the cycle after a reset edge, present pix_stb=0, active=0, hsync=vsync=~SYNC_POL, line_start=frame_start=0, pix_x=pix_y=0 and vblank_irq=0.
REQ-038 SHALL give reset priority over enable and vblank_ack; reset mid-frame restarts at h=0, v=0.
REQ-039 SHALL, with enable=1 from reset release, raise pix_stb for the first time CLK_DIV cycles after run goes high, together with frame_start.

Verification
REQ-040 Default params, CLK_DIV=1, enable=1 -> 420000 clk between frame_starts; 800 between line_starts; hsync low for h 656..751; vsync low for lines 490..491; active for 640x480 pixels per frame.
REQ-041 Small params H 4/1/2/1, V 3/1/1/1, CLK_DIV=2, SYNC_POL=1 -> pix_stb every 2nd clk; frame of 96 clk; hsync high for h 5..6; vsync high on v=4; active 12 pixels per frame.
REQ-042 Let vblank_irq set at v=480 h=0; pulse vblank_ack -> irq low the next cycle; ack pulsed in the setting cycle -> irq stays 1.
REQ-043 Drop enable at h=300, v=200 for 5 cycles, then raise it -> outputs idle while low; first pix_stb and frame_start at h=0, v=0; irq unchanged.
REQ-044 Assert resetn=0 mid-line with irq=1 -> next cycle all REQ-037 values, including vblank_irq=0; restart identical to the first power-up.
